// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage in front of the icache controller.
// Owns the program counter, presents the word address to the icache and loads
// the IF/ID pipeline register. Redirects that arrive while the icache is
// refilling are parked in pend_pc and only applied once miss_stall falls, so
// the icache never sees its fetch address move under an outstanding miss.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic [29:0] if_addr,
  output logic        rw,
  input  logic [31:0] cpu_data,
  input  logic        data_rdy,
  input  logic        miss_stall,
  output logic [31:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_en,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    IF_RUN       = 2'd0,
    IF_MISS      = 2'd1,
    IF_MISS_KILL = 2'd2
  } if_state_t;

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] pc_inc;
  logic [31:0] redir_target;
  logic        redirect;
  logic        fetch_ok;

  // data_rdy pulses seen during a refill are not trusted; only the re-hit
  // after miss_stall drops delivers the instruction.
  assign fetch_ok = data_rdy & ~miss_stall;

  // A hazard stall masks a resolved branch, but a flush always gets through.
  assign redirect     = flush | (br_taken & ~stall);
  assign redir_target = flush ? new_pc : br_addr;

  // Sequential fetch address, wrapping naturally at the top of the 32-bit space.
  assign pc_inc = pc + 32'd4;

  // The icache only ever reads from this stage.
  assign if_addr = pc[31:2];
  assign rw      = 1'b0;

  // The hazard unit must hold the pipeline while a miss or a parked redirect
  // is outstanding.
  assign fetch_busy = miss_stall | (state == IF_MISS_KILL);

  // Fetch FSM, PC, pending redirect and the IF/ID register.
  // IF_RUN and IF_MISS share one rule set: while miss_stall is high nothing
  // can complete or be applied in either, and once it is low IF_MISS behaves
  // exactly like IF_RUN (a redirect applies at once, a re-hit completes the
  // fetch). The state label only records that a miss was entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IF_RUN;
      pc      <= RESET_PC;
      pend_pc <= 32'h0000_0000;
      if_pc   <= 32'h0000_0000;
      if_insn <= NOP_INSN;
      if_en   <= 1'b0;
    end else begin
      case (state)
        IF_RUN, IF_MISS: begin
          if (redirect && !miss_stall) begin
            pc      <= redir_target;
            if_en   <= 1'b0;
            if_insn <= NOP_INSN;
            state   <= IF_RUN;
          end else if (redirect) begin
            pend_pc <= redir_target;
            if_en   <= 1'b0;
            state   <= IF_MISS_KILL;
          end else if (stall) begin
            state <= miss_stall ? IF_MISS : IF_RUN;
          end else if (fetch_ok) begin
            if_pc   <= pc;
            if_insn <= cpu_data;
            if_en   <= 1'b1;
            pc      <= pc_inc;
            state   <= IF_RUN;
          end else begin
            if_en   <= 1'b0;
            if_insn <= NOP_INSN;
            state   <= IF_MISS;
          end
        end
        IF_MISS_KILL: begin
          if_en <= 1'b0;
          if (!miss_stall) begin
            pc      <= redirect ? redir_target : pend_pc;
            if_insn <= NOP_INSN;
            state   <= IF_RUN;
          end else if (redirect) begin
            pend_pc <= redir_target;
          end
        end
        default: begin
          state <= IF_RUN;
          if_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage sitting directly upstream of the instruction cache controller. It owns the program counter and presents the word address to the icache. It consumes the returned instruction and hit/stall handshake and loads the IF/ID pipeline register. Branch and flush redirects that arrive during an icache miss are held back until the refill completes, so the icache always sees a stable fetch address.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset; bits [1:0] must be 0.
- `NOP_INSN`, default 32'h0000_0000: value loaded into `if_insn` on bubble, flush and reset.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low; asserts immediately, deasserts synchronously to `clk`.
- `stall` in 1: pipeline hazard stall; hold the PC and IF/ID register.
- `flush` in 1: pipeline flush/exception redirect.
- `new_pc` in 32: flush target (byte address).
- `br_taken` in 1: branch resolved taken.
- `br_addr` in 32: branch target (byte address).
- `if_addr` out 30: word address to the icache, always equal to `pc[31:2]`.
- `rw` out 1: icache read/write select, tied to READ (0).
- `cpu_data` in 32: instruction from the icache.
- `data_rdy` in 1: icache data valid.
- `miss_stall` in 1: icache miss in progress.
- `if_pc` out 32: IF/ID PC.
- `if_insn` out 32: IF/ID instruction.
- `if_en` out 1: IF/ID valid.
- `fetch_busy` out 1: to hazard unit; high while `miss_stall` is high or a redirect is pending.

## Operation
- Internal state: `pc[31:0]`, `pend_pc[31:0]`, and a 2-bit FSM with states `IF_RUN`, `IF_MISS`, `IF_MISS_KILL`.
- `fetch_ok = data_rdy & ~miss_stall`. This ignores the `data_rdy` pulses that occur during refill; the instruction is taken from the re-hit after `miss_stall` falls.
- Redirect target: `new_pc` if `flush` is high, otherwise `br_addr` if `br_taken` is high and `stall` is low. `flush` has priority. `br_taken` is ignored while `stall` is high.

FSM transitions, in `IF_RUN`, first match wins:
- Redirect and `miss_stall`=0: `pc` <= target; `if_en` <= 0; `if_insn` <= `NOP_INSN`; stay in `IF_RUN`.
- Redirect and `miss_stall`=1: `pend_pc` <= target; `if_en` <= 0; go to `IF_MISS_KILL`; `pc` held.
- `stall`: hold `pc`, `if_pc`, `if_insn`, `if_en`. Go to `IF_MISS` if `miss_stall`=1, otherwise stay.
- `fetch_ok`: `if_pc` <= `pc`; `if_insn` <= `cpu_data`; `if_en` <= 1; `pc` <= `pc`+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- Otherwise (miss): `if_en` <= 0; `if_insn` <= `NOP_INSN`; `pc` held; go to `IF_MISS`.

In `IF_MISS`:
- `pc` is held.
- A redirect moves to `IF_MISS_KILL`, latching `pend_pc` and clearing `if_en`.
- When `miss_stall`=0 and `fetch_ok`, the fetch completes as in `IF_RUN` and the FSM returns to `IF_RUN`.
- `stall` holds the IF/ID register, but the FSM still leaves `IF_MISS` when `miss_stall` falls.

In `IF_MISS_KILL`:
- `pc` is held; `if_en` = 0.
- A further redirect overwrites `pend_pc`; the newest redirect wins.
- When `miss_stall`=0: `pc` <= `pend_pc`; the delivered word is discarded; go to `IF_RUN`.

`fetch_busy` = `miss_stall` | (state == `IF_MISS_KILL`).

## Timing
- Reset values: `pc`=`RESET_PC`, `if_addr`=`RESET_PC[31:2]`, `if_pc`=0, `if_insn`=`NOP_INSN`, `if_en`=0, `pend_pc`=0, state `IF_RUN`, `fetch_busy`=`miss_stall`.
- `if_addr` is combinational from `pc`. It changes only on the clock edge following an accepted fetch or an applied redirect. It is never changed while `miss_stall`=1.
- Hit latency: the instruction appears on `if_insn` with `if_en`=1 at the first edge after `if_addr` is presented. One instruction per cycle is sustained on consecutive hits.
- Miss latency: the instruction is loaded on the first edge after `miss_stall` falls and the re-hit `data_rdy` is seen. `if_en`=0 for every intervening edge.
- A redirect with no miss takes effect at the next edge; the target is fetched in the following cycle. That gives one bubble (`if_en`=0) per redirect.
- Simultaneous `flush` and `br_taken`: `new_pc` is used.
- Simultaneous `stall` and `flush`: the flush wins.
- Reset mid-miss: the FSM returns to `IF_RUN` and `pc` to `RESET_PC` immediately. The pending redirect is lost.

## Test plan
- Reset, all hits, `cpu_data` = 32'h1000_0000 + pc: `if_pc` = 0, 4, 8 on consecutive edges, `if_insn` matching, `if_en`=1 from the first edge after reset release.
- Miss at pc 32'h40, with `miss_stall` high 5 cycles and `data_rdy` pulsed mid-fill: `if_addr` stays 30'h10 throughout; `if_en`=0; a single `if_insn` for 32'h40 after `miss_stall` falls; then pc 32'h44.
- `br_taken`=1 with `br_addr`=32'h200 during a miss: `fetch_busy`=1 until `miss_stall` falls; the 32'h40 word is not loaded (`if_en` stays 0); the next `if_addr`=30'h80.
- `flush` with `new_pc`=32'h100 and `br_taken` with `br_addr`=32'h300 in the same cycle: `pc`=32'h100, one bubble.
- `stall` held 3 cycles with `br_taken`=1: `pc`, `if_pc`, `if_insn`, `if_en` unchanged; the branch is taken only in the first cycle after `stall` falls.
- `rst` asserted low mid-miss, asynchronously between edges: outputs reach reset values immediately; after release, the fetch restarts at `RESET_PC`; PC wrap from 32'hFFFF_FFFC to 0 is checked separately.
